// File: rtl/btn_debounce.sv
// Push-button conditioner: per channel a 2-FF synchroniser, debounce FSM and press/release pulses.
// Optional auto-repeat on held buttons is built when BTN_DEBOUNCE_AUTOREPEAT_EN is defined.
module btn_debounce #(
  parameter int NUM_BTN         = 7,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 2500000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_BTN-1:0] i_btn,
  output logic [NUM_BTN-1:0] o_level,
  output logic [NUM_BTN-1:0] o_press,
  output logic [NUM_BTN-1:0] o_release
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } state_t;

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("btn_debounce: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  logic [NUM_BTN-1:0] btn_p0;
  logic [NUM_BTN-1:0] btn_p1;

  // Stage p0/p1: two-flop synchroniser for the asynchronous pins
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      btn_p0 <= '0;
      btn_p1 <= '0;
    end else begin
      btn_p0 <= i_btn;
      btn_p1 <= btn_p0;
    end
  end

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;
    logic             accept;
    logic             rep_fire;

    // The counter holds how many consecutive cycles btn_p1 has disagreed with the
    // accepted level; the edge that would make it DEBOUNCE_CYCLES is the accept edge.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      unique case (state_q)
        ST_STABLE: begin
          if (btn_p1[g] != level_q) begin
            if (DEBOUNCE_CYCLES == 1) begin
              accept = 1'b1;
            end else begin
              state_d = ST_COUNTING;
              cnt_d   = CNT_ONE;
            end
          end
        end
        ST_COUNTING: begin
          if (btn_p1[g] == level_q) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            accept  = 1'b1;
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end
      endcase
    end

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_ONE      = REP_W'(1);
    localparam logic [REP_W-1:0] REP_DLY_LAST = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_PER_LAST = REP_W'(REPEAT_PERIOD - 1);

    logic [REP_W-1:0] rep_q, rep_d;
    logic             armed_q, armed_d;

    // First repeat after REPEAT_DELAY, then every REPEAT_PERIOD once armed
    always_comb begin
      rep_d    = rep_q;
      armed_d  = armed_q;
      rep_fire = 1'b0;
      if (accept || !level_q) begin
        rep_d   = '0;
        armed_d = 1'b0;
      end else if (rep_q == (armed_q ? REP_PER_LAST : REP_DLY_LAST)) begin
        rep_fire = 1'b1;
        rep_d    = '0;
        armed_d  = 1'b1;
      end else begin
        rep_d = rep_q + REP_ONE;
      end
    end

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        rep_q   <= '0;
        armed_q <= 1'b0;
      end else begin
        rep_q   <= rep_d;
        armed_q <= armed_d;
      end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_comb begin
      level_d = level_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      if (accept) begin
        level_d = btn_p1[g];
        press_d = btn_p1[g];
        rel_d   = ~btn_p1[g];
      end else if (rep_fire) begin
        press_d = 1'b1;
      end
    end

    // Stage p2: filter state and registered outputs
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        state_q <= ST_STABLE;
        cnt_q   <= '0;
        level_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        level_q <= level_d;
        press_q <= press_d;
        rel_q   <= rel_d;
      end
    end

    assign o_level[g]   = level_q;
    assign o_press[g]   = press_q;
    assign o_release[g] = rel_q;
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with DEBOUNCE_CYCLES=4: vector table plus corner-case sequences.
module tb_btn_debounce;
  localparam int NB = 7;
  localparam int DC = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] btn;
  logic [NB-1:0] level;
  logic [NB-1:0] press;
  logic [NB-1:0] rel;

  int checks = 0;
  int errors = 0;

  btn_debounce #(
    .NUM_BTN(NB), .DEBOUNCE_CYCLES(DC), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_btn(btn),
    .o_level(level), .o_press(press), .o_release(rel)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          rst;
    logic [NB-1:0] btn;
    logic [NB-1:0] lvl;
    logic [NB-1:0] prs;
    logic [NB-1:0] rls;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [NB-1:0] b, input logic [NB-1:0] l,
                     input logic [NB-1:0] p, input logic [NB-1:0] e, input int n);
    vec_t v;
    v.rst = r; v.btn = b; v.lvl = l; v.prs = p; v.rls = e;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  initial begin
    int npress, nrel, nlvl, rise;

    // rst, btn, level, press, release, repeat count
    add(1'b1, 7'h00, 7'h00, 7'h00, 7'h00, 2);
    add(1'b0, 7'h01, 7'h00, 7'h00, 7'h00, 5);
    add(1'b0, 7'h01, 7'h01, 7'h01, 7'h00, 1);
    add(1'b0, 7'h01, 7'h01, 7'h00, 7'h00, 2);
    add(1'b0, 7'h00, 7'h01, 7'h00, 7'h00, 5);
    add(1'b0, 7'h00, 7'h00, 7'h00, 7'h01, 1);
    add(1'b0, 7'h00, 7'h00, 7'h00, 7'h00, 1);
    add(1'b0, 7'h55, 7'h00, 7'h00, 7'h00, 5);
    add(1'b0, 7'h55, 7'h55, 7'h55, 7'h00, 1);
    add(1'b0, 7'h55, 7'h55, 7'h00, 7'h00, 1);
    add(1'b1, 7'h55, 7'h00, 7'h00, 7'h00, 1);
    add(1'b0, 7'h55, 7'h00, 7'h00, 7'h00, 5);
    add(1'b0, 7'h55, 7'h55, 7'h55, 7'h00, 1);
    add(1'b0, 7'h55, 7'h55, 7'h00, 7'h00, 1);
    add(1'b0, 7'h00, 7'h55, 7'h00, 7'h00, 5);
    add(1'b0, 7'h00, 7'h00, 7'h00, 7'h55, 1);
    add(1'b0, 7'h00, 7'h00, 7'h00, 7'h00, 2);

    rst = 1'b1;
    btn = '0;
    tick();
    tick();
    chk("reset level", level, 7'h00);
    chk("reset press", press, 7'h00);
    chk("reset release", rel, 7'h00);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("idle%0d", i), level | press | rel, 7'h00);
    end

    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      btn = vecs[i].btn;
      tick();
      chk($sformatf("vec%0d level", i), level, vecs[i].lvl);
      chk($sformatf("vec%0d press", i), press, vecs[i].prs);
      chk($sformatf("vec%0d release", i), rel, vecs[i].rls);
    end

    // Bounce on channel 2, then a steady hold
    npress = 0; nrel = 0; nlvl = 0; rise = -1;
    for (int k = 0; k < 8; k++) begin
      btn[2] = ((k / 2) % 2) == 0;
      tick();
      npress += int'(press[2]);
      nrel   += int'(rel[2]);
      nlvl   += int'(level[2]);
    end
    chk_int("bounce no press", npress, 0);
    chk_int("bounce no level", nlvl, 0);
    btn[2] = 1'b1;
    for (int j = 0; j < 10; j++) begin
      tick();
      if (level[2] && rise < 0) rise = j;
      npress += int'(press[2]);
      nrel   += int'(rel[2]);
    end
    chk_int("bounce rise edge", rise, 5);
    chk_int("bounce press count", npress, 1);
    chk_int("bounce release count", nrel, 0);
    btn[2] = 1'b0;
    for (int j = 0; j < 8; j++) begin
      tick();
      nrel += int'(rel[2]);
    end
    chk_int("bounce release pulse", nrel, 1);
    chk("bounce settled", level, 7'h00);

    // Reset landing on the accept edge suppresses the pulse
    btn[4] = 1'b1;
    for (int j = 0; j < 5; j++) tick();
    chk("pre-accept level", level, 7'h00);
    rst = 1'b1;
    tick();
    chk("rst at accept level", level, 7'h00);
    chk("rst at accept press", press, 7'h00);
    rst = 1'b0;
    for (int j = 0; j < 5; j++) tick();
    chk("reaccept before", level, 7'h00);
    tick();
    chk("reaccept press", press, 7'h10);
    chk("reaccept level", level, 7'h10);
    btn[4] = 1'b0;
    for (int j = 0; j < 8; j++) tick();
    chk("ch4 released", level, 7'h00);

    // Release on channel 3 interrupted by reset two cycles into the count
    btn[3] = 1'b1;
    for (int j = 0; j < 7; j++) tick();
    chk("ch3 held level", level, 7'h08);
    btn[3] = 1'b0;
    nrel = 0;
    for (int j = 0; j < 3; j++) begin
      tick();
      nrel += int'(rel[3]);
    end
    rst = 1'b1;
    tick();
    nrel += int'(rel[3]);
    chk("mid-count rst level", level, 7'h00);
    rst = 1'b0;
    btn[3] = 1'b1;
    npress = 0;
    rise = -1;
    for (int j = 0; j < 6; j++) begin
      tick();
      nrel += int'(rel[3]);
      npress += int'(press[3]);
      if (press[3] && rise < 0) rise = j;
    end
    chk_int("mid-count no release", nrel, 0);
    chk_int("fresh press edge", rise, 5);
    chk_int("fresh press count", npress, 1);
    btn[3] = 1'b0;
    for (int j = 0; j < 8; j++) tick();
    chk("ch3 released", level, 7'h00);

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    // Auto-repeat on channel 1: accept at 5, repeats at 15 then every 3; release accepted at 36
    btn[1] = 1'b1;
    for (int j = 0; j < 46; j++) begin
      logic ep, er;
      if (j == 31) btn[1] = 1'b0;
      tick();
      ep = (j == 5) || (j >= 15 && j <= 33 && ((j - 15) % 3) == 0);
      er = (j == 36);
      chk($sformatf("rep%0d press", j), {6'b0, press[1]}, {6'b0, ep});
      chk($sformatf("rep%0d release", j), {6'b0, rel[1]}, {6'b0, er});
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
